cache_req_master: RTL and testbench

- Requester-side counterpart of the tag-lookup cache controller. It accepts CPU byte addresses on a valid/ready port and splits each into tag/index/offset.
- It drives the controller's index/tag request handshake, consumes its hit_miss/col response handshake, and returns the result to the CPU side.
- Keeps saturating hit/miss statistics and a sticky protocol-error flag.
- Single outstanding lookup; sits between the load/store front end and the cache controller.

---
 rtl/cache_req_master.sv | 114 +++++++++++
 tb/tb_cache_req_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_master.sv
// Requester side of the tag-lookup cache controller: splits CPU addresses,
// runs one index/tag lookup at a time and returns hit/way with statistics.
module cache_req_master #(
   parameter int addr_width   = 32,
   parameter int offset_width = 6,
   parameter int index_width  = 10,
   parameter int tag_width    = 16,
   parameter int cnt_width    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [addr_width-1:0]  req_addr,
   input  logic                   req_valid,
   output logic                   req_ready,
   output logic                   rsp_hit,
   output logic [1:0]             rsp_col,
   output logic [index_width-1:0] rsp_index,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [index_width-1:0] c_index,
   output logic [tag_width-1:0]   c_tag,
   output logic                   c_it_valid,
   input  logic                   c_it_ready,
   input  logic                   c_hit_miss,
   input  logic [1:0]             c_col,
   input  logic                   c_hm_valid,
   output logic                   c_hm_ready,
   input  logic                   clr_stats,
   output logic [cnt_width-1:0]   hit_cnt,
   output logic [cnt_width-1:0]   miss_cnt,
   output logic                   proto_err,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t                 state;
   logic [index_width-1:0] idx_q;
   logic [tag_width-1:0]   tag_q;
   logic                   hm_hs;

   assign hm_hs = c_hm_valid && (state == WAIT);

   // Handshake strobes are gated by rst_n so they drop the instant reset asserts.
   assign req_ready  = rst_n && (state == IDLE);
   assign c_it_valid = rst_n && (state == ISSUE);
   assign c_hm_ready = rst_n && (state == WAIT);
   assign rsp_valid  = rst_n && (state == RESP);
   assign busy       = (state != IDLE);
   assign c_index    = idx_q;
   assign c_tag      = tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx_q     <= '0;
         tag_q     <= '0;
         rsp_hit   <= 1'b0;
         rsp_col   <= 2'b00;
         rsp_index <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  tag_q <= req_addr[addr_width-1 -: tag_width];
                  idx_q <= req_addr[offset_width +: index_width];
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (c_it_ready) state <= WAIT;
            end
            WAIT: begin
               if (c_hm_valid) begin
                  rsp_hit   <= c_hit_miss;
                  rsp_col   <= c_hit_miss ? c_col : 2'b00;
                  rsp_index <= idx_q;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Clear wins over a same-cycle count or error; counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         proto_err <= 1'b0;
      end else if (clr_stats) begin
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         proto_err <= 1'b0;
      end else begin
         if (hm_hs && c_hit_miss && (hit_cnt != '1))
            hit_cnt <= hit_cnt + cnt_width'(1);
         if (hm_hs && !c_hit_miss && (miss_cnt != '1))
            miss_cnt <= miss_cnt + cnt_width'(1);
         if (c_hm_valid && (state != WAIT))
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_req_master.sv
// Bench for cache_req_master: transaction-level model plus a small
// tag-store controller model, with directed lookups and literal pins.
module tb_cache_req_master;
   localparam int AW = 32;
   localparam int OW = 6;
   localparam int IW = 10;
   localparam int TW = 16;
   localparam int CW = 4;
   localparam logic [CW-1:0] CMAX = '1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [AW-1:0] req_addr;
   logic req_valid, req_ready;
   logic rsp_hit, rsp_valid, rsp_ready;
   logic [1:0] rsp_col;
   logic [IW-1:0] rsp_index, c_index;
   logic [TW-1:0] c_tag;
   logic c_it_valid, c_it_ready, c_hit_miss, c_hm_valid, c_hm_ready;
   logic [1:0] c_col;
   logic clr_stats;
   logic [CW-1:0] hit_cnt, miss_cnt;
   logic proto_err, busy;

   cache_req_master #(
      .addr_width(AW), .offset_width(OW), .index_width(IW),
      .tag_width(TW), .cnt_width(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
      .rsp_hit(rsp_hit), .rsp_col(rsp_col), .rsp_index(rsp_index),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .c_index(c_index), .c_tag(c_tag),
      .c_it_valid(c_it_valid), .c_it_ready(c_it_ready),
      .c_hit_miss(c_hit_miss), .c_col(c_col),
      .c_hm_valid(c_hm_valid), .c_hm_ready(c_hm_ready),
      .clr_stats(clr_stats), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
      .proto_err(proto_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Controller model: tag store, one-cycle compare, fill on miss.
   bit [TW-1:0] t_tag [1<<IW];
   bit          t_vld [1<<IW];
   bit [1:0]    t_way [1<<IW];
   int ph = 0;
   int stall = 0;
   bit spur = 1'b0;
   bit [1:0] fill_way = 2'd2;
   bit [IW-1:0] k_idx;
   bit [TW-1:0] k_tag;
   bit k_hit;

   initial begin
      c_it_ready = 1'b0;
      c_hm_valid = 1'b0;
      c_hit_miss = 1'b0;
      c_col = 2'd0;
      forever begin
         @(negedge clk);
         c_hm_valid = 1'b0;
         if (!rst_n) begin
            ph = 0;
            stall = 0;
            c_it_ready = 1'b0;
         end else begin
            case (ph)
               0: begin
                  if (spur) begin
                     c_hm_valid = 1'b1;
                     c_hit_miss = 1'b1;
                     c_col = 2'd1;
                     spur = 1'b0;
                  end
                  if (c_it_valid && stall > 0) begin
                     c_it_ready = 1'b0;
                     stall--;
                  end else begin
                     c_it_ready = 1'b1;
                     if (c_it_valid) begin
                        k_idx = c_index;
                        k_tag = c_tag;
                        ph = 1;
                     end
                  end
               end
               1: begin
                  c_it_ready = 1'b0;
                  ph = 2;
               end
               default: begin
                  k_hit = t_vld[k_idx] && (t_tag[k_idx] == k_tag);
                  c_hm_valid = 1'b1;
                  c_hit_miss = k_hit;
                  c_col = k_hit ? t_way[k_idx] : 2'd3;
                  if (c_hm_ready) begin
                     if (!k_hit) begin
                        t_vld[k_idx] = 1'b1;
                        t_tag[k_idx] = k_tag;
                        t_way[k_idx] = fill_way;
                     end
                     ph = 0;
                  end
               end
            endcase
         end
      end
   end

   // Transaction-level reference: one lookup in flight, tracked as
   // accepted / issued / answered, plus expected statistics.
   bit m_busy, m_iss, m_ans, m_hs, m_err;
   bit [IW-1:0] m_idx;
   bit [TW-1:0] m_tag;
   bit m_rhit;
   bit [1:0] m_col;
   bit [CW-1:0] m_hc, m_mc;

   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_c_it_valid", c_it_valid, 0);
         chk("rst_c_hm_ready", c_hm_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_hit_cnt", hit_cnt, 0);
         chk("rst_miss_cnt", miss_cnt, 0);
         chk("rst_proto_err", proto_err, 0);
         m_busy = 0; m_iss = 0; m_ans = 0;
         m_hc = '0; m_mc = '0; m_err = 0;
      end else begin
         chk("req_ready", req_ready, !m_busy);
         chk("c_it_valid", c_it_valid, m_busy && !m_iss);
         chk("c_hm_ready", c_hm_ready, m_iss && !m_ans);
         chk("rsp_valid", rsp_valid, m_ans);
         chk("busy", busy, m_busy);
         if (m_busy && !m_iss) begin
            chk("c_index", c_index, m_idx);
            chk("c_tag", c_tag, m_tag);
         end
         if (m_ans) begin
            chk("rsp_hit", rsp_hit, m_rhit);
            chk("rsp_col", rsp_col, m_col);
            chk("rsp_index", rsp_index, m_idx);
         end
         chk("hit_cnt", hit_cnt, m_hc);
         chk("miss_cnt", miss_cnt, m_mc);
         chk("proto_err", proto_err, m_err);
         m_hs = m_iss && !m_ans && c_hm_valid;
         if (clr_stats) begin
            m_hc = '0; m_mc = '0; m_err = 0;
         end else begin
            if (c_hm_valid && !(m_iss && !m_ans)) m_err = 1;
            if (m_hs && c_hit_miss && m_hc != CMAX) m_hc++;
            if (m_hs && !c_hit_miss && m_mc != CMAX) m_mc++;
         end
         if (!m_busy) begin
            if (req_valid) begin
               m_busy = 1;
               m_idx = IW'(req_addr / (1 << OW));
               m_tag = TW'(req_addr >> (AW - TW));
            end
         end else if (!m_iss) begin
            if (c_it_ready) m_iss = 1;
         end else if (!m_ans) begin
            if (c_hm_valid) begin
               m_ans = 1;
               m_rhit = c_hit_miss;
               m_col = c_hit_miss ? c_col : 2'd0;
            end
         end else if (rsp_ready) begin
            m_busy = 0; m_iss = 0; m_ans = 0;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [AW-1:0] a, output int acc);
      acc = -1;
      req_addr = a;
      req_valid = 1'b1;
      for (int i = 0; i < 40 && acc < 0; i++) begin
         if (req_ready) acc = cyc;
         step();
      end
      req_valid = 1'b0;
      if (acc < 0) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_rsp(output int rc);
      rc = -1;
      for (int i = 0; i < 40 && rc < 0; i++) begin
         if (rsp_valid) rc = cyc;
         else step();
      end
      if (rc < 0) chk("rsp_timeout", 0, 1);
   endtask

   task automatic lookup(input logic [AW-1:0] a);
      int acc, rc;
      send(a, acc);
      wait_rsp(rc);
      step();
   endtask

   task automatic wait_hm_ready();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (c_hm_ready) seen = 1'b1;
         else step();
      end
      if (!seen) chk("hm_ready_timeout", 0, 1);
   endtask

   int a0, r0, a1, r1, a2, cnt_rv;
   bit seen_hs;

   initial begin
      req_addr = '0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      clr_stats = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) step();
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      rst_n = 1'b1;
      step();
      chk("idle_req_ready", req_ready, 1);

      // single miss
      send(32'h0001_2340, a0);
      chk("miss_c_it_valid", c_it_valid, 1);
      chk("miss_c_index", c_index, 10'h08D);
      chk("miss_c_tag", c_tag, 16'h0001);
      wait_rsp(r0);
      chk("miss_latency", r0 - a0, 4);
      chk("miss_rsp_hit", rsp_hit, 0);
      chk("miss_rsp_col", rsp_col, 0);
      step();
      chk("miss_cnt_1", miss_cnt, 1);

      // repeat after fill, then a back-to-back lookup
      send(32'h0001_2340, a1);
      wait_rsp(r1);
      chk("hit_rsp_hit", rsp_hit, 1);
      chk("hit_rsp_col", rsp_col, 2);
      chk("hit_cnt_1", hit_cnt, 1);
      send(32'h0001_2380, a2);
      chk("turnaround", a2 - a1, 5);
      wait_rsp(r1);
      step();

      // backpressure on both handshakes
      stall = 3;
      rsp_ready = 1'b0;
      send(32'hABCD_5FC0, a0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_c_it_valid", c_it_valid, 1);
         chk("bp_c_index", c_index, 10'h17F);
         chk("bp_c_tag", c_tag, 16'hABCD);
         chk("bp_req_ready", req_ready, 0);
         step();
      end
      wait_rsp(r0);
      chk("bp_latency", r0 - a0, 7);
      for (int i = 0; i < 4; i++) begin
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_index", rsp_index, 10'h17F);
         chk("bp_rsp_col", rsp_col, 0);
         chk("bp_req_ready_rsp", req_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_retired", rsp_valid, 0);
      chk("bp_idle", req_ready, 1);

      // spurious response pulse while idle
      spur = 1'b1;
      step();
      step();
      chk("spur_proto_err", proto_err, 1);
      chk("spur_busy", busy, 0);
      chk("spur_hit_cnt", hit_cnt, 1);
      lookup(32'h0001_2340);
      chk("spur_after_hit_cnt", hit_cnt, 2);
      chk("spur_sticky", proto_err, 1);

      // clear, then saturate the hit counter
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      chk("clr_proto_err", proto_err, 0);
      chk("clr_miss_cnt", miss_cnt, 0);
      for (int i = 0; i < 17; i++) lookup(32'h0001_2340);
      chk("sat_hit_cnt", hit_cnt, 15);
      send(32'h0001_2340, a0);
      seen_hs = 1'b0;
      for (int i = 0; i < 40 && !seen_hs; i++) begin
         if (c_hm_valid && c_hm_ready) seen_hs = 1'b1;
         else step();
      end
      if (!seen_hs) chk("clr_hs_timeout", 0, 1);
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      chk("clr_vs_hit", hit_cnt, 0);
      wait_rsp(r0);
      step();
      lookup(32'h0001_2340);
      chk("post_clr_hit_cnt", hit_cnt, 1);

      // asynchronous reset while waiting on the controller
      send(32'h0000_0040, a0);
      wait_hm_ready();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_c_hm_ready", c_hm_ready, 0);
      chk("arst_req_ready", req_ready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_hit_cnt", hit_cnt, 0);
      step();
      step();
      rst_n = 1'b1;
      cnt_rv = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) cnt_rv++;
         step();
      end
      chk("arst_no_rsp", cnt_rv, 0);
      chk("arst_idle", req_ready, 1);
      send(32'h0000_0040, a0);
      wait_rsp(r0);
      chk("arst_recover_hit", rsp_hit, 0);
      chk("arst_recover_index", rsp_index, 10'h001);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
